pico_ctrl_exec: RTL and testbench



---
 rtl/pico.sv | 64 ++++++
 rtl/pico_alu.sv | 58 +++++
 rtl/pico_ctrl_exec.sv | 150 +++++++++++++++
 tb/tb_pico_ctrl_exec.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pico.sv
// Shared parameters and types for the pico core: widths, opcodes, ALU functions,
// PC modes and the {z,n,c,v} flag word.
package pico;

  localparam int N        = 8;
  localparam int A        = 8;
  localparam int W_IMM    = 8;
  localparam int W_RADDR  = 3;
  localparam int W_OPCODE = 5;
  localparam int W_INST   = W_OPCODE + 2 * W_RADDR + W_IMM;

  typedef enum logic [W_OPCODE-1:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_ADDI = 5'h02,
    OP_SUB  = 5'h03,
    OP_SUBI = 5'h04,
    OP_AND  = 5'h05,
    OP_ANDI = 5'h06,
    OP_OR   = 5'h07,
    OP_ORI  = 5'h08,
    OP_XOR  = 5'h09,
    OP_XORI = 5'h0A,
    OP_MOV  = 5'h0B,
    OP_LDI  = 5'h0C,
    OP_SHL  = 5'h0D,
    OP_SHR  = 5'h0E,
    OP_CMP  = 5'h0F,
    OP_JMP  = 5'h10,
    OP_BZ   = 5'h11,
    OP_BNZ  = 5'h12,
    OP_BC   = 5'h13,
    OP_BNC  = 5'h14,
    OP_BN   = 5'h15,
    OP_WFI  = 5'h16,
    OP_HLT  = 5'h1F
  } opCode;

  typedef enum logic [3:0] {
    ALU_PASS_A,
    ALU_PASS_B,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR
  } funcALU;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_REL  = 2'd1,
    PC_HOLD = 2'd2
  } modePC;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flagsALU;

endpackage

// File: rtl/pico_alu.sv
// Combinational ALU of the pico core: result plus {z,n,c,v} flags for one function.
module pico_alu
  import pico::*;
(
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  funcALU       func_i,
  output logic [N-1:0] result_o,
  output flagsALU      flags_o
);

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] res;
  logic         c;
  logic         v;

  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    res  = a_i;
    c    = 1'b0;
    v    = 1'b0;
    case (func_i)
      ALU_PASS_A: res = a_i;
      ALU_PASS_B: res = b_i;
      ALU_ADD: begin
        res = sum[N-1:0];
        c   = sum[N];
        v   = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      ALU_SUB: begin
        // diff[N] is the unsigned borrow (a < b)
        res = diff[N-1:0];
        c   = diff[N];
        v   = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      ALU_SHL: begin
        res = {a_i[N-2:0], 1'b0};
        c   = a_i[N-1];
      end
      ALU_SHR: begin
        res = {a_i[N-1], a_i[N-1:1]};
        c   = a_i[0];
      end
      default: res = a_i;
    endcase
    result_o  = res;
    flags_o.z = (res == '0);
    flags_o.n = res[N-1];
    flags_o.c = c;
    flags_o.v = v;
  end

endmodule

// File: rtl/pico_ctrl_exec.sv
// Control + execute stage of the pico core: decode, ALU, flags, HLT and WFI sequencing.
// Interrupt edge detection and WFI are built only when PICO_INT_EN is defined.
module pico_ctrl_exec
  import pico::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [W_INST-1:0] instr_i,
  input  logic [N-1:0]      rd_data_i,
  input  logic [N-1:0]      rs_data_i,
  input  logic              ext_int_i,
  output logic [N-1:0]      alu_result_o,
  output logic              wr_en_rf_o,
  output logic [1:0]        mode_pc_o,
  output logic [3:0]        flags_o,
  output logic              halt_o,
  output logic              wfi_o
);

  opCode               op;
  logic [W_IMM-1:0]    imm;
  logic signed [N-1:0] imm_ext;
  funcALU              func;
  logic                use_imm;
  logic                wr_op;
  logic                flag_op;
  logic                taken;
  logic                is_hlt;
  logic                wfi_op;
  logic                wfi_wait;
  logic [N-1:0]        alu_a;
  logic [N-1:0]        alu_res;
  flagsALU             alu_flags;
  flagsALU             flags_q, flags_d;
  logic                halt_q, halt_d;
  modePC               mode;

  assign op      = opCode'(instr_i[W_INST-1 -: W_OPCODE]);
  assign imm     = instr_i[W_IMM-1:0];
  assign imm_ext = N'($signed(imm));

  always_comb begin
    func    = ALU_PASS_A;
    use_imm = 1'b0;
    wr_op   = 1'b0;
    flag_op = 1'b0;
    taken   = 1'b0;
    is_hlt  = 1'b0;
    wfi_op  = 1'b0;
    case (op)
      OP_ADD:  begin func = ALU_ADD;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_ADDI: begin func = ALU_ADD;    wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_SUB:  begin func = ALU_SUB;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_SUBI: begin func = ALU_SUB;    wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_AND:  begin func = ALU_AND;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_ANDI: begin func = ALU_AND;    wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_OR:   begin func = ALU_OR;     wr_op = 1'b1; flag_op = 1'b1; end
      OP_ORI:  begin func = ALU_OR;     wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_XOR:  begin func = ALU_XOR;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_XORI: begin func = ALU_XOR;    wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_MOV:  begin func = ALU_PASS_B; wr_op = 1'b1; flag_op = 1'b1; end
      OP_LDI:  begin func = ALU_PASS_A; wr_op = 1'b1; flag_op = 1'b1; use_imm = 1'b1; end
      OP_SHL:  begin func = ALU_SHL;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_SHR:  begin func = ALU_SHR;    wr_op = 1'b1; flag_op = 1'b1; end
      OP_CMP:  begin func = ALU_SUB;    flag_op = 1'b1; end
      OP_JMP:  taken  = 1'b1;
      OP_BZ:   taken  = flags_q.z;
      OP_BNZ:  taken  = ~flags_q.z;
      OP_BC:   taken  = flags_q.c;
      OP_BNC:  taken  = ~flags_q.c;
      OP_BN:   taken  = flags_q.n;
      OP_WFI:  wfi_op = 1'b1;
      OP_HLT:  is_hlt = 1'b1;
      default: func   = ALU_PASS_A;
    endcase
  end

  assign alu_a = use_imm ? imm_ext : rd_data_i;

  pico_alu u_alu (
    .a_i      (alu_a),
    .b_i      (rs_data_i),
    .func_i   (func),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  // A HLT in flight already counts as halted, so it blocks its own side effects.
  assign halt_o       = halt_q | is_hlt;
  assign halt_d       = halt_o;
  assign alu_result_o = alu_res;
  assign wr_en_rf_o   = wr_op & ~halt_o;
  assign flags_d      = (flag_op && !halt_o) ? alu_flags : flags_q;
  assign flags_o      = flags_q;

`ifdef PICO_INT_EN
  logic int_q, int_d;
  logic pending_q, pending_d;
  logic int_edge;
  logic wake;

  always_comb begin
    int_edge  = ext_int_i & ~int_q;
    wake      = pending_q | int_edge;
    int_d     = ext_int_i;
    pending_d = pending_q | int_edge;
    // A waking WFI consumes the pending request, including one that arrives this cycle.
    if (wfi_op && !halt_o && wake) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_q     <= ext_int_i;
      pending_q <= 1'b0;
    end else begin
      int_q     <= int_d;
      pending_q <= pending_d;
    end
  end

  assign wfi_wait = wfi_op & ~halt_o & ~wake;
`else
  logic unused_int;
  assign unused_int = ext_int_i ^ wfi_op;
  assign wfi_wait   = 1'b0;
`endif

  assign wfi_o = wfi_wait;

  always_comb begin
    mode = PC_INC;
    if (halt_o || wfi_wait) mode = PC_HOLD;
    else if (taken)         mode = PC_REL;
  end
  assign mode_pc_o = mode;

  logic unused_raddr;
  assign unused_raddr = ^instr_i[W_IMM +: 2*W_RADDR];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      halt_q  <= halt_d;
    end
  end

endmodule

// File: tb/tb_pico_ctrl_exec.sv
// Bench for pico_ctrl_exec: vector table for ALU/branch/flags behaviour plus
// sequences for HLT, reset and (with PICO_INT_EN) the WFI/interrupt handshake.
module tb_pico_ctrl_exec;
  import pico::*;

  typedef struct {
    logic [18:0] instr;
    logic [7:0]  rd;
    logic [7:0]  rs;
    logic        ext;
    logic        chk_res;
    logic [7:0]  res;
    logic        wr;
    logic [1:0]  mode;
    logic [3:0]  flags;
    logic        halt;
    logic        wfi;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [18:0] instr_i = '0;
  logic [7:0]  rd_data_i = '0;
  logic [7:0]  rs_data_i = '0;
  logic        ext_int_i = 1'b0;
  logic [7:0]  alu_result_o;
  logic        wr_en_rf_o;
  logic [1:0]  mode_pc_o;
  logic [3:0]  flags_o;
  logic        halt_o;
  logic        wfi_o;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t exp_q[$];
  vec_t tbl[21];

  pico_ctrl_exec dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .rd_data_i    (rd_data_i),
    .rs_data_i    (rs_data_i),
    .ext_int_i    (ext_int_i),
    .alu_result_o (alu_result_o),
    .wr_en_rf_o   (wr_en_rf_o),
    .mode_pc_o    (mode_pc_o),
    .flags_o      (flags_o),
    .halt_o       (halt_o),
    .wfi_o        (wfi_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [7:0] imm);
    return {op, 3'd1, 3'd2, imm};
  endfunction

  function automatic vec_t mkv(input logic [18:0] instr, input logic [7:0] rd, input logic [7:0] rs,
                               input logic ext, input logic chk_res, input logic [7:0] res,
                               input logic wr, input logic [1:0] mode, input logic [3:0] flags,
                               input logic halt, input logic wfi);
    vec_t v;
    v.instr = instr; v.rd = rd; v.rs = rs; v.ext = ext; v.chk_res = chk_res; v.res = res;
    v.wr = wr; v.mode = mode; v.flags = flags; v.halt = halt; v.wfi = wfi;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic do_reset(input logic [18:0] instr, input logic ext);
    @(posedge clk_i); #1;
    rst_i = 1'b1; instr_i = instr; ext_int_i = ext;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; instr_i = mk(OP_NOP, 8'h00);
  endtask

  // Drive one vector after a rising edge, queue its expectation, compare at the falling edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk_i); #1;
    instr_i = v.instr; rd_data_i = v.rd; rs_data_i = v.rs; ext_int_i = v.ext;
    exp_q.push_back(v);
    @(negedge clk_i);
    e = exp_q.pop_front();
    if (e.chk_res) check("result", idx, alu_result_o, e.res);
    check("wr_en", idx, {7'd0, wr_en_rf_o}, {7'd0, e.wr});
    check("mode", idx, {6'd0, mode_pc_o}, {6'd0, e.mode});
    check("flags", idx, {4'd0, flags_o}, {4'd0, e.flags});
    check("halt", idx, {7'd0, halt_o}, {7'd0, e.halt});
    check("wfi", idx, {7'd0, wfi_o}, {7'd0, e.wfi});
  endtask

  initial begin
    // flags nibble is {z,n,c,v} as seen before the vector's own edge
    tbl[0]  = mkv(mk(OP_ADD,  8'h00), 8'h7F, 8'h01, 0, 1, 8'h80, 1, 2'd0, 4'b0000, 0, 0);
    tbl[1]  = mkv(mk(OP_NOP,  8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0101, 0, 0);
    tbl[2]  = mkv(mk(OP_SUB,  8'h00), 8'h05, 8'h05, 0, 1, 8'h00, 1, 2'd0, 4'b0101, 0, 0);
    tbl[3]  = mkv(mk(OP_BZ,   8'hFD), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd1, 4'b1000, 0, 0);
    tbl[4]  = mkv(mk(OP_BNZ,  8'hFD), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b1000, 0, 0);
    tbl[5]  = mkv(mk(OP_ADDI, 8'hFF), 8'h00, 8'h01, 0, 1, 8'h00, 1, 2'd0, 4'b1000, 0, 0);
    tbl[6]  = mkv(mk(OP_CMP,  8'h00), 8'h03, 8'h04, 0, 1, 8'hFF, 0, 2'd0, 4'b1010, 0, 0);
    tbl[7]  = mkv(mk(OP_BC,   8'h02), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd1, 4'b0110, 0, 0);
    tbl[8]  = mkv(mk(OP_BN,   8'h02), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd1, 4'b0110, 0, 0);
    tbl[9]  = mkv(mk(OP_BNC,  8'h02), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0110, 0, 0);
    tbl[10] = mkv(mk(OP_JMP,  8'h02), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd1, 4'b0110, 0, 0);
    tbl[11] = mkv(mk(OP_AND,  8'h00), 8'hF0, 8'h3C, 0, 1, 8'h30, 1, 2'd0, 4'b0110, 0, 0);
    tbl[12] = mkv(mk(OP_XORI, 8'h0F), 8'h00, 8'hFF, 0, 1, 8'hF0, 1, 2'd0, 4'b0000, 0, 0);
    tbl[13] = mkv(mk(OP_SHL,  8'h00), 8'h81, 8'h00, 0, 1, 8'h02, 1, 2'd0, 4'b0100, 0, 0);
    tbl[14] = mkv(mk(OP_SHR,  8'h00), 8'h81, 8'h00, 0, 1, 8'hC0, 1, 2'd0, 4'b0010, 0, 0);
    tbl[15] = mkv(mk(OP_MOV,  8'h00), 8'h00, 8'h5A, 0, 1, 8'h5A, 1, 2'd0, 4'b0110, 0, 0);
    tbl[16] = mkv(mk(OP_LDI,  8'h80), 8'h00, 8'h00, 0, 1, 8'h80, 1, 2'd0, 4'b0000, 0, 0);
    tbl[17] = mkv(mk(OP_OR,   8'h00), 8'h01, 8'h02, 0, 1, 8'h03, 1, 2'd0, 4'b0100, 0, 0);
    tbl[18] = mkv(mk(OP_SUB,  8'h00), 8'h80, 8'h01, 0, 1, 8'h7F, 1, 2'd0, 4'b0000, 0, 0);
    tbl[19] = mkv(mk(5'h17,   8'h00), 8'h12, 8'h34, 0, 0, 8'h00, 0, 2'd0, 4'b0001, 0, 0);
    tbl[20] = mkv(mk(OP_NOP,  8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0001, 0, 0);

    do_reset(mk(OP_NOP, 8'h00), 1'b0);
    @(negedge clk_i);
    check("rst_flags", 0, {4'd0, flags_o}, 8'h00);
    check("rst_halt", 0, {7'd0, halt_o}, 8'h00);
    check("rst_wfi", 0, {7'd0, wfi_o}, 8'h00);
    check("rst_wr", 0, {7'd0, wr_en_rf_o}, 8'h00);
    check("rst_mode", 0, {6'd0, mode_pc_o}, 8'h00);

    for (int i = 0; i < 21; i++) apply(tbl[i], i);

    // HLT holds the core; writes and flag updates are suppressed until reset
    do_reset(mk(OP_NOP, 8'h00), 1'b0);
    apply(mkv(mk(OP_HLT, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd2, 4'b0000, 1, 0), 100);
    apply(mkv(mk(OP_ADD, 8'h00), 8'h00, 8'h00, 0, 1, 8'h00, 0, 2'd2, 4'b0000, 1, 0), 101);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd2, 4'b0000, 1, 0), 102);
    apply(mkv(mk(OP_JMP, 8'h04), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd2, 4'b0000, 1, 0), 103);
    do_reset(mk(OP_NOP, 8'h00), 1'b0);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 104);
    // HLT presented during reset must not leave the core halted
    do_reset(mk(OP_HLT, 8'h00), 1'b0);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 105);

`ifdef PICO_INT_EN
    do_reset(mk(OP_NOP, 8'h00), 1'b0);
    for (int i = 0; i < 5; i++)
      apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd2, 4'b0000, 0, 1), 200 + i);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 205);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd2, 4'b0000, 0, 1), 206);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 207);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 208);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 209);
    apply(mkv(mk(OP_NOP, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 210);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 211);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd2, 4'b0000, 0, 1), 212);
    // line already high across reset is not an edge
    do_reset(mk(OP_NOP, 8'h00), 1'b1);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd2, 4'b0000, 0, 1), 213);
`else
    do_reset(mk(OP_NOP, 8'h00), 1'b0);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 300);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 1, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 301);
    apply(mkv(mk(OP_WFI, 8'h00), 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000, 0, 0), 302);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
